cdb_bus_scheduler: RTL and testbench

// Central grant side of the common-data-bus (CDB) protocol. Collects get_bus

---
 rtl/cdb_pkg.sv | 16 +
 rtl/cdb_bus_scheduler_rr_pick_first.sv | 35 +++
 rtl/cdb_bus_scheduler.sv | 98 +++++++++
 tb/tb_cdb_bus_scheduler.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/cdb_pkg.sv
// Shared CDB definitions used by the bus scheduler and the producer-side arbiters.
// Address 0 means "bus disconnected"; device index i drives address i+1.
package cdb_pkg;

    localparam int CDB_ADDR_W      = 4;
    localparam int CDB_MAX_DEVICES = 15;

    typedef logic [CDB_ADDR_W-1:0] cdb_addr_t;

    localparam cdb_addr_t CDB_NONE = 4'h0;

    function automatic cdb_addr_t cdb_index_to_addr(input cdb_addr_t idx);
        return idx + 1'b1;
    endfunction

endpackage

// File: rtl/cdb_bus_scheduler_rr_pick_first.sv
// Wrap-around priority pick: first set bit of req at or after base.
// The request vector is rotated so the search becomes a plain lowest-set-bit find.
module rr_pick_first #(
    parameter int N     = 15,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] base,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    localparam logic [IDX_W:0] N_W = (IDX_W+1)'(N);

    logic [N-1:0]            rot;
    logic [N-1:0]            lowest;
    logic [N:0][IDX_W-1:0]   enc;
    logic [IDX_W:0]          sum;

    assign rot    = N'({req, req} >> base);
    assign lowest = rot & (~rot + 1'b1);

    // One-hot to binary of the offset from base
    assign enc[0] = '0;
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_enc
            assign enc[gi+1] = enc[gi] | (lowest[gi] ? IDX_W'(gi) : '0);
        end
    endgenerate

    assign sum   = {1'b0, base} + {1'b0, enc[N]};
    assign idx   = (sum >= N_W) ? IDX_W'(sum - N_W) : sum[IDX_W-1:0];
    assign valid = |req;

endmodule

// File: rtl/cdb_bus_scheduler.sv
// CDB grant scheduler: round-robin assignment of eligible producers to enabled
// buses, with registered select/grant outputs and one-cycle lockout after a grant.
module cdb_bus_scheduler
    import cdb_pkg::*;
#(
    parameter int CDB_COUNT = 2,
    parameter int DEV_COUNT = 15
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic [DEV_COUNT-1:0]            request,
    input  logic [CDB_COUNT-1:0]            bus_enable,
    input  logic                            flush,
    output logic [CDB_ADDR_W*CDB_COUNT-1:0] select,
    output logic [DEV_COUNT-1:0]            grant_vec
);

    localparam int IDX_W = (DEV_COUNT > 1) ? $clog2(DEV_COUNT) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEV_COUNT - 1);

    generate
        if (DEV_COUNT < 1 || DEV_COUNT > CDB_MAX_DEVICES) begin : g_bad_dev_count
            $error("cdb_bus_scheduler: DEV_COUNT must be in 1..15");
        end
        if (CDB_COUNT < 1) begin : g_bad_cdb_count
            $error("cdb_bus_scheduler: CDB_COUNT must be at least 1");
        end
    endgenerate

    logic [IDX_W-1:0]                    rr_ptr_reg, rr_ptr_next;
    logic [DEV_COUNT-1:0]                grant_vec_reg, grant_vec_next;
    logic [CDB_ADDR_W*CDB_COUNT-1:0]     select_reg, select_next;
    logic [DEV_COUNT-1:0]                eligible;

    logic [CDB_COUNT-1:0][DEV_COUNT-1:0] pick_req;
    logic [CDB_COUNT-1:0][IDX_W-1:0]     pick_idx;
    logic [CDB_COUNT-1:0]                pick_valid;
    logic [CDB_COUNT-1:0]                bus_grant;
    logic [CDB_COUNT-1:0][DEV_COUNT-1:0] grant_onehot;
    logic [CDB_COUNT:0][DEV_COUNT-1:0]   gv_acc;
    logic [CDB_COUNT:0][IDX_W-1:0]       ptr_acc;

    // The registered grant vector doubles as the lockout mask
    assign eligible = request & ~grant_vec_reg;

    assign pick_req[0] = eligible;
    assign gv_acc[0]   = '0;
    assign ptr_acc[0]  = rr_ptr_reg;

    generate
        for (genvar gi = 0; gi < CDB_COUNT; gi++) begin : g_bus
            rr_pick_first #(
                .N     (DEV_COUNT),
                .IDX_W (IDX_W)
            ) u_pick (
                .req   (pick_req[gi]),
                .base  (rr_ptr_reg),
                .idx   (pick_idx[gi]),
                .valid (pick_valid[gi])
            );

            assign bus_grant[gi]    = bus_enable[gi] & pick_valid[gi] & ~flush;
            assign grant_onehot[gi] = DEV_COUNT'(bus_grant[gi]) << pick_idx[gi];

            assign select_next[gi*CDB_ADDR_W +: CDB_ADDR_W] = bus_grant[gi]
                ? cdb_index_to_addr(CDB_ADDR_W'(pick_idx[gi])) : CDB_NONE;

            // A disabled bus consumes no device, so the next bus sees the same candidates
            if (gi + 1 < CDB_COUNT) begin : g_chain
                assign pick_req[gi+1] = pick_req[gi] & ~grant_onehot[gi];
            end

            assign gv_acc[gi+1]  = gv_acc[gi] | grant_onehot[gi];
            assign ptr_acc[gi+1] = !bus_grant[gi] ? ptr_acc[gi]
                                 : (pick_idx[gi] == LAST_IDX) ? '0
                                 : pick_idx[gi] + 1'b1;
        end
    endgenerate

    assign grant_vec_next = gv_acc[CDB_COUNT];
    assign rr_ptr_next    = ptr_acc[CDB_COUNT];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            select_reg    <= '0;
            grant_vec_reg <= '0;
            rr_ptr_reg    <= '0;
        end else begin
            select_reg    <= select_next;
            grant_vec_reg <= grant_vec_next;
            rr_ptr_reg    <= rr_ptr_next;
        end
    end

    assign select    = select_reg;
    assign grant_vec = grant_vec_reg;

endmodule

// File: tb/tb_cdb_bus_scheduler.sv
// Bench for cdb_bus_scheduler: directed vector table, a registered-output check,
// then randomized traffic against a queue-based scan-order reference model.
module tb_cdb_bus_scheduler;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [14:0] request;
    logic [1:0]  bus_enable;
    logic        flush;
    logic [7:0]  select;
    logic [14:0] grant_vec;

    int n_vec = 0;
    int n_bad = 0;

    logic [7:0]  m_sel;
    logic [14:0] m_gv;
    int          m_ptr;

    typedef struct {
        logic        rn;
        logic [14:0] req;
        logic [1:0]  en;
        logic        fl;
        logic [7:0]  sel;
        logic [14:0] gv;
    } vec_t;

    vec_t vecs [$];

    always #5 clk = ~clk;

    cdb_bus_scheduler #(
        .CDB_COUNT (2),
        .DEV_COUNT (15)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .request    (request),
        .bus_enable (bus_enable),
        .flush      (flush),
        .select     (select),
        .grant_vec  (grant_vec)
    );

    task automatic drive(input logic rn, input logic [14:0] req,
                         input logic [1:0] en, input logic fl);
        reset_n    = rn;
        request    = req;
        bus_enable = en;
        flush      = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [7:0] exp_sel,
                         input logic [14:0] exp_gv);
        n_vec++;
        if (select !== exp_sel || grant_vec !== exp_gv) begin
            n_bad++;
            $display("FAIL %s: got select=%h grant_vec=%h, want select=%h grant_vec=%h",
                     name, select, grant_vec, exp_sel, exp_gv);
        end else begin
            $display("ok   %s: select=%h grant_vec=%h", name, select, grant_vec);
        end
    endtask

    // Reference: list eligible devices in scan order from the pointer, then hand
    // them out to enabled buses in ascending bus order.
    task automatic model_step(input logic rn, input logic [14:0] req,
                              input logic [1:0] en, input logic fl);
        int          cand [$];
        int          nb;
        logic [14:0] g;
        logic [3:0]  a;
        if (!rn) begin
            m_sel = '0;
            m_gv  = '0;
            m_ptr = 0;
        end else if (fl) begin
            m_sel = '0;
            m_gv  = '0;
        end else begin
            for (int o = 0; o < 15; o++) begin
                int d;
                d = (m_ptr + o) % 15;
                if (req[d[3:0]] && !m_gv[d[3:0]]) cand.push_back(d);
            end
            g     = '0;
            m_sel = '0;
            nb    = 0;
            for (int k = 0; k < 2; k++) begin
                if (en[k] && nb < cand.size()) begin
                    a = 4'(cand[nb] + 1);
                    if (k == 0) m_sel[3:0] = a;
                    else        m_sel[7:4] = a;
                    g[4'(cand[nb])] = 1'b1;
                    m_ptr = (cand[nb] + 1) % 15;
                    nb++;
                end
            end
            m_gv = g;
        end
    endtask

    initial begin
        logic        rn, fl;
        logic [14:0] req;
        logic [1:0]  en;

        vecs = '{
            '{1'b0, 15'h7FFF, 2'b11, 1'b0, 8'h00, 15'h0000},
            '{1'b0, 15'h7FFF, 2'b11, 1'b0, 8'h00, 15'h0000},
            '{1'b0, 15'h7FFF, 2'b11, 1'b0, 8'h00, 15'h0000},
            '{1'b1, 15'h0005, 2'b11, 1'b0, 8'h31, 15'h0005},
            '{1'b1, 15'h0005, 2'b11, 1'b0, 8'h00, 15'h0000},
            '{1'b1, 15'h0003, 2'b11, 1'b1, 8'h00, 15'h0000},
            '{1'b1, 15'h0003, 2'b11, 1'b0, 8'h21, 15'h0003},
            '{1'b0, 15'h7FFF, 2'b11, 1'b0, 8'h00, 15'h0000},
            '{1'b1, 15'h0007, 2'b10, 1'b0, 8'h10, 15'h0001},
            '{1'b1, 15'h0007, 2'b10, 1'b0, 8'h20, 15'h0002},
            '{1'b1, 15'h0007, 2'b01, 1'b0, 8'h03, 15'h0004},
            '{1'b1, 15'h0000, 2'b11, 1'b0, 8'h00, 15'h0000},
            '{1'b0, 15'h7FFF, 2'b11, 1'b0, 8'h00, 15'h0000},
            '{1'b1, 15'h7FFF, 2'b11, 1'b0, 8'h21, 15'h0003},
            '{1'b1, 15'h7FFF, 2'b11, 1'b0, 8'h43, 15'h000C},
            '{1'b1, 15'h7FFF, 2'b11, 1'b0, 8'h65, 15'h0030},
            '{1'b1, 15'h7FFF, 2'b11, 1'b0, 8'h87, 15'h00C0},
            '{1'b1, 15'h7FFF, 2'b11, 1'b0, 8'hA9, 15'h0300},
            '{1'b1, 15'h7FFF, 2'b11, 1'b0, 8'hCB, 15'h0C00},
            '{1'b1, 15'h7FFF, 2'b11, 1'b0, 8'hED, 15'h3000},
            '{1'b1, 15'h7FFF, 2'b11, 1'b0, 8'h1F, 15'h4001},
            '{1'b1, 15'h7FFF, 2'b11, 1'b0, 8'h32, 15'h0006},
            '{1'b0, 15'h7FFF, 2'b11, 1'b0, 8'h00, 15'h0000},
            '{1'b1, 15'h7FFF, 2'b11, 1'b0, 8'h21, 15'h0003},
            '{1'b1, 15'h7FFF, 2'b00, 1'b0, 8'h00, 15'h0000},
            '{1'b0, 15'h7FFF, 2'b11, 1'b1, 8'h00, 15'h0000},
            '{1'b1, 15'h7FFF, 2'b11, 1'b0, 8'h21, 15'h0003},
            '{1'b1, 15'h7FFF, 2'b11, 1'b1, 8'h00, 15'h0000},
            '{1'b1, 15'h7FFF, 2'b11, 1'b0, 8'h43, 15'h000C},
            '{1'b1, 15'h0001, 2'b11, 1'b0, 8'h01, 15'h0001},
            '{1'b1, 15'h0001, 2'b11, 1'b0, 8'h00, 15'h0000},
            '{1'b1, 15'h0001, 2'b11, 1'b0, 8'h01, 15'h0001},
            '{1'b1, 15'h4000, 2'b10, 1'b0, 8'hF0, 15'h4000}
        };

        reset_n    = 1'b0;
        request    = '1;
        bus_enable = 2'b11;
        flush      = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rn, vecs[i].req, vecs[i].en, vecs[i].fl);
            check($sformatf("table[%0d]", i), vecs[i].sel, vecs[i].gv);
        end

        // Outputs must not follow input changes until the next edge
        drive(1'b1, 15'h0005, 2'b11, 1'b0);
        check("regd_grant", 8'h31, 15'h0005);
        request    = '0;
        bus_enable = 2'b00;
        flush      = 1'b1;
        #2;
        check("no_comb_path", 8'h31, 15'h0005);
        @(posedge clk);
        #1;
        check("flush_after_hold", 8'h00, 15'h0000);

        drive(1'b0, 15'h7FFF, 2'b11, 1'b0);
        model_step(1'b0, 15'h7FFF, 2'b11, 1'b0);
        check("rand_reset", m_sel, m_gv);

        for (int i = 0; i < 1500; i++) begin
            rn = ($urandom_range(0, 63) != 0);
            fl = ($urandom_range(0, 15) == 0);
            en = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0:       req = 15'($urandom);
                1:       req = 15'($urandom & $urandom & $urandom);
                2:       req = '1;
                default: req = 15'(1) << $urandom_range(0, 14);
            endcase
            drive(rn, req, en, fl);
            model_step(rn, req, en, fl);
            check($sformatf("rand[%0d] rn=%b fl=%b en=%b req=%h", i, rn, fl, en, req),
                  m_sel, m_gv);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
